// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter shared by instruction fetch and data access.
// Data requests win ties; each access holds the SRAM for WAIT_CYCLES+1 cycles.
// Done flags remember finished accesses until the pipeline stops stalling.
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        sram_ce_o,
  output logic        sram_we_o,
  output logic [3:0]  sram_sel_o,
  output logic [31:0] sram_addr_o,
  output logic [31:0] sram_wdata_o,
  input  logic [31:0] sram_rdata_i,
  input  logic        flush_i,
  output logic        stallreq_o
);

  localparam logic [3:0] WaitCnt = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StData, StInst} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        d_done_q, d_done_d;
  logic        i_done_q, i_done_d;
  // Remembers a flush seen during the current data access.
  logic        flushed_q, flushed_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] mem_data_q, mem_data_d;

  assign stallreq_o = (mem_ce_i & ~d_done_q) | (if_ce_i & ~i_done_q);
  assign if_data_o  = if_data_q;
  assign mem_data_o = mem_data_q;

  // Next-state, done-flag bookkeeping and SRAM bus decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    d_done_d     = d_done_q;
    i_done_d     = i_done_q;
    flushed_d    = flushed_q;
    if_data_d    = if_data_q;
    mem_data_d   = mem_data_q;
    sram_ce_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_sel_o   = 4'b0000;
    sram_addr_o  = 32'h0;
    sram_wdata_o = 32'h0;

    // Pipeline advanced or was flushed: forget finished accesses.
    if (!stallreq_o || flush_i) begin
      d_done_d = 1'b0;
      i_done_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        flushed_d = 1'b0;
        if (mem_ce_i && !d_done_q) begin
          state_d = StData;
          cnt_d   = WaitCnt;
        end else if (if_ce_i && !i_done_q) begin
          state_d = StInst;
          cnt_d   = WaitCnt;
        end
      end
      StData: begin
        sram_ce_o    = 1'b1;
        sram_we_o    = mem_we_i;
        sram_sel_o   = mem_sel_i;
        sram_addr_o  = mem_addr_i;
        sram_wdata_o = mem_data_i;
        if (cnt_q != 4'd0) begin
          cnt_d     = cnt_q - 4'd1;
          flushed_d = flushed_q | flush_i;
        end else begin
          // Writes are never aborted; a flushed access just is not reported done.
          state_d   = StIdle;
          flushed_d = 1'b0;
          d_done_d  = !(flushed_q || flush_i);
          if (!mem_we_i) mem_data_d = sram_rdata_i;
        end
      end
      StInst: begin
        sram_ce_o   = 1'b1;
        sram_sel_o  = 4'b1111;
        sram_addr_o = if_addr_i;
        if (flush_i) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d   = StIdle;
          i_done_d  = 1'b1;
          if_data_d = sram_rdata_i;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      d_done_q   <= 1'b0;
      i_done_q   <= 1'b0;
      flushed_q  <= 1'b0;
      if_data_q  <= 32'h0;
      mem_data_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      d_done_q   <= d_done_d;
      i_done_q   <= i_done_d;
      flushed_q  <= flushed_d;
      if_data_q  <= if_data_d;
      mem_data_q <= mem_data_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations, then random traffic checked every cycle against a model.
module tb_mem_arbiter;

  localparam int W = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_ce_i = 1'b0;
  logic [31:0] if_addr_i = 32'h0;
  logic        mem_ce_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [3:0]  mem_sel_i = 4'h0;
  logic [31:0] mem_addr_i = 32'h0;
  logic [31:0] mem_data_i = 32'h0;
  logic [31:0] sram_rdata_i = 32'h0;
  logic        flush_i = 1'b0;

  logic [31:0] if_data_o, mem_data_o, sram_addr_o, sram_wdata_o;
  logic        sram_ce_o, sram_we_o, stallreq_o;
  logic [3:0]  sram_sel_o;
  logic [31:0] if_data0, mem_data0, sram_addr0, sram_wdata0;
  logic        sram_ce0, sram_we0, stall0;
  logic [3:0]  sram_sel0;

  mem_arbiter #(.WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst(rst), .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .mem_data_o(mem_data_o), .sram_ce_o(sram_ce_o),
    .sram_we_o(sram_we_o), .sram_sel_o(sram_sel_o), .sram_addr_o(sram_addr_o),
    .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i), .flush_i(flush_i),
    .stallreq_o(stallreq_o)
  );

  // Zero-wait variant, only checked in the lone-fetch scenario.
  mem_arbiter #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data0),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .mem_data_o(mem_data0), .sram_ce_o(sram_ce0),
    .sram_we_o(sram_we0), .sram_sel_o(sram_sel0), .sram_addr_o(sram_addr0),
    .sram_wdata_o(sram_wdata0), .sram_rdata_i(sram_rdata_i), .flush_i(flush_i),
    .stallreq_o(stall0)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  // Model: which access owns the SRAM (0 none, 1 data, 2 inst) and cycles left.
  int          m_kind = 0;
  int          m_left = 0;
  logic        m_dd = 1'b0, m_id = 1'b0, m_fl = 1'b0;
  logic [31:0] m_if = 32'h0, m_md = 32'h0;

  always @(posedge clk or negedge rst) begin : model
    logic st, nd, ni;
    if (!rst) begin
      m_kind = 0; m_left = 0; m_dd = 1'b0; m_id = 1'b0; m_fl = 1'b0;
      m_if = 32'h0; m_md = 32'h0;
    end else begin
      st = (mem_ce_i && !m_dd) || (if_ce_i && !m_id);
      nd = m_dd;
      ni = m_id;
      if (!st || flush_i) begin nd = 1'b0; ni = 1'b0; end
      case (m_kind)
        0: begin
          m_fl = 1'b0;
          if (mem_ce_i && !m_dd) begin m_kind = 1; m_left = W + 1; end
          else if (if_ce_i && !m_id) begin m_kind = 2; m_left = W + 1; end
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_kind = 0;
            if (!mem_we_i) m_md = sram_rdata_i;
            nd = !(m_fl || flush_i);
            m_fl = 1'b0;
          end else begin
            m_fl = m_fl | flush_i;
          end
        end
        default: begin
          if (flush_i) begin
            m_kind = 0;
          end else begin
            m_left--;
            if (m_left == 0) begin m_kind = 0; ni = 1'b1; m_if = sram_rdata_i; end
          end
        end
      endcase
      m_dd = nd;
      m_id = ni;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", {31'h0, stallreq_o}, {31'h0, (mem_ce_i & ~m_dd) | (if_ce_i & ~m_id)});
      chk("if_data", if_data_o, m_if);
      chk("mem_data", mem_data_o, m_md);
      chk("sram_ce", {31'h0, sram_ce_o}, {31'h0, m_kind != 0});
      chk("sram_we", {31'h0, sram_we_o}, {31'h0, m_kind == 1 && mem_we_i});
      chk("sram_sel", {28'h0, sram_sel_o},
          {28'h0, m_kind == 1 ? mem_sel_i : (m_kind == 2 ? 4'hF : 4'h0)});
      chk("sram_addr", sram_addr_o,
          m_kind == 1 ? mem_addr_i : (m_kind == 2 ? if_addr_i : 32'h0));
      if (m_kind != 2) chk("sram_wdata", sram_wdata_o, m_kind == 1 ? mem_data_i : 32'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #600000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, n0, ce_n;
    bit seen, seen0;
    logic [9:0] pat;
    logic [31:0] a1;

    repeat (2) tick();
    rst = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst_if_data", if_data_o, 32'h0);
    chk("rst_mem_data", mem_data_o, 32'h0);
    chk("rst_sram_ce", {31'h0, sram_ce_o}, 32'h0);
    chk("rst_stall", {31'h0, stallreq_o}, 32'h0);

    // Lone fetch: 3 stalled cycles with one wait state, 2 with none.
    tick();
    if_ce_i = 1'b1; if_addr_i = 32'h100; sram_rdata_i = 32'h3C011234;
    n = 0; n0 = 0; ce_n = 0; seen = 0; seen0 = 0; a1 = 32'h0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (!seen) begin
        if (stallreq_o) n++; else seen = 1;
        if (sram_ce_o) begin ce_n++; a1 = sram_addr_o; end
      end
      if (!seen0) begin if (stall0) n0++; else seen0 = 1; end
      if (seen && seen0) break;
      tick();
    end
    if_ce_i = 1'b0;
    chk("fetch_stall_cycles", n, 3);
    chk("fetch_stall_cycles_w0", n0, 2);
    chk("fetch_inst_cycles", ce_n, 2);
    chk("fetch_addr", a1, 32'h100);
    chk("fetch_data", if_data_o, 32'h3C011234);
    chk("fetch_data_w0", if_data0, 32'h3C011234);

    // Simultaneous requests: DATA, DATA, IDLE, INST, INST.
    tick();
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h200;
    if_ce_i = 1'b1; if_addr_i = 32'h300; sram_rdata_i = 32'hDEADBEEF;
    pat = 10'h0; n = 0; a1 = 32'h0;
    for (int k = 0; k < 10; k++) begin
      #1;
      pat[k] = sram_ce_o;
      if (k == 1) a1 = sram_addr_o;
      if (!stallreq_o) break;
      n++;
      tick();
    end
    mem_ce_i = 1'b0; if_ce_i = 1'b0;
    chk("both_stall_cycles", n, 6);
    chk("both_ce_pattern", {22'h0, pat}, 32'h36);
    chk("both_data_addr", a1, 32'h200);
    chk("both_mem_data", mem_data_o, 32'hDEADBEEF);

    // Partial write: byte enables pass through, read result untouched.
    tick();
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b0011; mem_addr_i = 32'h40;
    mem_data_i = 32'h0000ABCD; sram_rdata_i = 32'h12345678;
    n = 0; a1 = 32'h0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (sram_we_o && sram_sel_o == 4'b0011) begin n++; a1 = sram_wdata_o; end
      if (!stallreq_o) break;
      tick();
    end
    mem_ce_i = 1'b0; mem_we_i = 1'b0;
    chk("write_cycles", n, 2);
    chk("write_wdata", a1, 32'h0000ABCD);
    chk("write_mem_data_kept", mem_data_o, 32'hDEADBEEF);

    // Flush during INST aborts the fetch.
    tick();
    if_ce_i = 1'b1; if_addr_i = 32'h500; sram_rdata_i = 32'h11111111;
    tick();
    #1 chk("flush_inst_started", {31'h0, sram_ce_o}, 32'h1);
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; if_ce_i = 1'b0;
    #1 chk("flush_inst_idle", {31'h0, sram_ce_o}, 32'h0);
    chk("flush_inst_data_kept", if_data_o, 32'hDEADBEEF);

    // Flush early in a DATA write: write finishes, not reported done.
    tick();
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'hF; mem_addr_i = 32'h80;
    mem_data_i = 32'h55;
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    #1 chk("flush_data_continues", {31'h0, sram_ce_o & sram_we_o}, 32'h1);
    tick();
    #1 chk("flush_data_idle", {31'h0, sram_ce_o}, 32'h0);
    chk("flush_data_not_done", {31'h0, stallreq_o}, 32'h1);
    mem_ce_i = 1'b0; mem_we_i = 1'b0;
    tick();

    // Asynchronous reset in the middle of a DATA read.
    mem_ce_i = 1'b1; mem_addr_i = 32'h200; sram_rdata_i = 32'hCAFEF00D;
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_sram_ce", {31'h0, sram_ce_o}, 32'h0);
    chk("arst_sram_addr", sram_addr_o, 32'h0);
    chk("arst_mem_data", mem_data_o, 32'h0);
    chk("arst_if_data", if_data_o, 32'h0);
    chk("arst_stall", {31'h0, stallreq_o}, 32'h1);
    @(posedge clk);
    #3 rst = 1'b1;
    tick();
    n = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (!stallreq_o) break;
      n++;
      tick();
    end
    mem_ce_i = 1'b0;
    chk("post_rst_stall_cycles", n, 2);
    chk("post_rst_mem_data", mem_data_o, 32'hCAFEF00D);
    tick();

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      mem_ce_i     = ($urandom_range(0, 99) < 40);
      mem_we_i     = $urandom_range(0, 1) == 1;
      mem_sel_i    = 4'($urandom);
      mem_addr_i   = $urandom;
      mem_data_i   = $urandom;
      if_ce_i      = ($urandom_range(0, 99) < 60);
      if_addr_i    = $urandom;
      sram_rdata_i = $urandom;
      flush_i      = ($urandom_range(0, 15) == 0);
      tick();
    end
    flush_i = 1'b0;
    mem_ce_i = 1'b0;
    if_ce_i = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
